// File: rtl/dieu_khien_chinh_gio.sv
// Adjust-mode controller for the digital clock: debounced MODE/INC,
// RUN/SEC/MIN/HOUR cycling, increment strobes, hold-repeat, timeout.
module dieu_khien_chinh_gio #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] gt_mod,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       run_en
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (HW > RW) ? HW : RW;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    SEC  = 2'b01,
    MIN  = 2'b10,
    HOUR = 2'b11
  } state_e;

  // bit 0 = MODE, bit 1 = INC
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         deb_q, deb_d, debp_q;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  state_e        state_q, state_d;
  logic [2:0]    inc_q, inc_d;
  logic          rep_on_q, rep_on_d;
  logic          rep_ph_q, rep_ph_d;
  logic [PW-1:0] rep_cnt_q, rep_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic          mode_ev, inc_ev, adj;
  logic          timeout, rep_fire;
  logic [2:0]    inc_sel;
  logic [PW-1:0] rep_lim;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]  = deb_q[b];
      dcnt_d[b] = '0;
      if (s2_q[b] != deb_q[b]) begin
        if (dcnt_q[b] == DW'(DEBOUNCE_CYCLES - 1))
          deb_d[b] = s2_q[b];
        else
          dcnt_d[b] = dcnt_q[b] + DW'(1);
      end
    end
  end

  always_comb begin
    mode_ev  = deb_q[0] & ~debp_q[0];
    inc_ev   = deb_q[1] & ~debp_q[1];
    adj      = state_q != RUN;
    inc_sel  = {state_q == HOUR, state_q == MIN, state_q == SEC};
    rep_lim  = rep_ph_q ? PW'(REPEAT_CYCLES - 1)
                        : PW'(HOLD_CYCLES - 1);
    timeout  = adj && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    rep_fire = rep_on_q && deb_q[1] && adj
               && (rep_cnt_q == rep_lim);

    state_d   = state_q;
    inc_d     = '0;
    rep_on_d  = rep_on_q & deb_q[1];
    rep_ph_d  = rep_ph_q;
    rep_cnt_d = rep_on_q ? rep_cnt_q + PW'(1) : '0;
    to_cnt_d  = adj ? to_cnt_q + TW'(1) : '0;

    // mode beats timeout beats INC press beats repeat
    if (mode_ev) begin
      state_d  = state_e'(state_q + 2'd1);
      rep_on_d = 1'b0;
      to_cnt_d = '0;
    end else if (timeout) begin
      state_d  = RUN;
      rep_on_d = 1'b0;
      to_cnt_d = '0;
    end else if (inc_ev && adj) begin
      inc_d     = inc_sel;
      rep_on_d  = 1'b1;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
      to_cnt_d  = '0;
    end else if (rep_fire) begin
      inc_d     = inc_sel;
      rep_ph_d  = 1'b1;
      rep_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '1;
      s2_q      <= '1;
      deb_q     <= '1;
      debp_q    <= '1;
      dcnt_q    <= '0;
      state_q   <= RUN;
      inc_q     <= '0;
      rep_on_q  <= 1'b0;
      rep_ph_q  <= 1'b0;
      rep_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      s1_q      <= {btn_inc, btn_mode};
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      debp_q    <= deb_q;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      inc_q     <= inc_d;
      rep_on_q  <= rep_on_d;
      rep_ph_q  <= rep_ph_d;
      rep_cnt_q <= rep_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign gt_mod   = state_q;
  assign run_en   = state_q == RUN;
  assign inc_sec  = inc_q[0];
  assign inc_min  = inc_q[1];
  assign inc_hour = inc_q[2];

endmodule

// File: tb/tb_dieu_khien_chinh_gio.sv
// Bench for dieu_khien_chinh_gio: directed scenarios plus random
// button activity against an event-level reference model.
module tb_dieu_khien_chinh_gio;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam int T = 100;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] gt_mod;
  logic       inc_sec, inc_min, inc_hour, run_en;

  dieu_khien_chinh_gio #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .gt_mod(gt_mod),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .run_en(run_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state, all in absolute edge numbers
  int     n = 0;
  int     m = 0;
  int     strobe = 0;
  bit     rep_on = 0;
  int     next_rep = 0;
  int     last_evt = 0;
  bit     dm = 1, dmp = 1, di = 1, dip = 1;
  bit [D:0] hm = '1, hi = '1;

  int min_log[$];
  int oth_cnt = 0;
  int stb_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // a level is accepted once D consecutive synchronised samples disagree
  task automatic model_edge();
    bit mev, iev, tmo, rf;
    n++;
    if (!rst_n) begin
      m = 0; strobe = 0; rep_on = 0;
      dm = 1; dmp = 1; di = 1; dip = 1;
      hm = '1; hi = '1;
    end else begin
      mev = dm & ~dmp;
      iev = di & ~dip;
      tmo = (m != 0) && (n - last_evt == T);
      rf  = rep_on && (m != 0) && di && (n == next_rep);
      strobe = 0;
      if (mev) begin
        m = (m + 1) % 4; rep_on = 0; last_evt = n;
      end else if (tmo) begin
        m = 0; rep_on = 0;
      end else if (iev && m != 0) begin
        strobe = m; rep_on = 1; next_rep = n + H; last_evt = n;
      end else if (rf) begin
        strobe = m; next_rep = n + R; last_evt = n;
      end
      if (!di) rep_on = 0;
      dmp = dm;
      dip = di;
      if (hm[D:1] == {D{~dm}}) dm = ~dm;
      if (hi[D:1] == {D{~di}}) di = ~di;
      hm = {hm[D-1:0], btn_mode};
      hi = {hi[D-1:0], btn_inc};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gt_mod", gt_mod, m);
    chk("run_en", run_en, m == 0);
    chk("inc_sec", inc_sec, strobe == 1);
    chk("inc_min", inc_min, strobe == 2);
    chk("inc_hour", inc_hour, strobe == 3);
    if (inc_min) min_log.push_back(n);
    if (inc_sec || inc_hour) oth_cnt++;
    if (inc_sec || inc_min || inc_hour) stb_cnt++;
  endtask

  task automatic hold(input int k);
    repeat (k) step();
  endtask

  task automatic press(input bit which, input int len,
                       output int t_raise);
    t_raise = n;
    if (which) btn_inc = 1'b1;
    else btn_mode = 1'b1;
    hold(len);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    hold(D + 5);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int tr, n0, t_ev;
    int off[6];
    logic [1:0] exp_mod[4];
    off = '{0, 20, 28, 36, 44, 52};
    exp_mod = '{2'b01, 2'b10, 2'b11, 2'b00};
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    hold(3);
    rst_n = 1'b1;
    chk("rst_gt_mod", gt_mod, 0);
    chk("rst_run_en", run_en, 1);
    hold(10);

    // bounce 1,0,1 then held
    btn_mode = 1'b1; step();
    btn_mode = 1'b0; step();
    btn_mode = 1'b1;
    hold(6);
    chk("t1_before", gt_mod, 0);
    step();
    chk("t1_latency", gt_mod, 1);
    hold(20);
    chk("t1_single", gt_mod, 1);
    btn_mode = 1'b0;
    hold(D + 5);

    // four clean presses from reset
    do_reset();
    hold(10);
    for (int i = 0; i < 4; i++) begin
      press(0, D + 5, tr);
      chk("t2_gt_mod", gt_mod, exp_mod[i]);
      chk("t2_run_en", run_en, i == 3);
    end

    // hold-to-repeat in MIN
    press(0, D + 5, tr);
    press(0, D + 5, tr);
    chk("t3_state", gt_mod, 2);
    min_log.delete();
    oth_cnt = 0;
    n0 = n;
    btn_inc = 1'b1;
    hold(60);
    btn_inc = 1'b0;
    hold(20);
    chk("t3_count", min_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < min_log.size())
        chk("t3_time", min_log[i], n0 + 7 + off[i]);
    chk("t3_other", oth_cnt, 0);

    // simultaneous MODE and INC in SEC
    press(0, D + 5, tr);
    press(0, D + 5, tr);
    press(0, D + 5, tr);
    chk("t4_state", gt_mod, 1);
    stb_cnt = 0;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    hold(D + 5);
    chk("t4_gt_mod", gt_mod, 2);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    hold(D + 5);
    chk("t4_strobes", stb_cnt, 0);

    // timeout from HOUR, then INC ignored in RUN
    press(0, D + 5, tr);
    t_ev = tr + D + 3;
    chk("t5_state", gt_mod, 3);
    while (n < t_ev + T - 1) step();
    chk("t5_before", gt_mod, 3);
    step();
    chk("t5_timeout", gt_mod, 0);
    stb_cnt = 0;
    press(1, D + 5, tr);
    chk("t5_run_inc", stb_cnt, 0);
    chk("t5_run_mod", gt_mod, 0);

    // MODE held through reset
    btn_mode = 1'b1;
    hold(D + 5);
    chk("t6_pre", gt_mod, 1);
    do_reset();
    hold(30);
    chk("t6_held", gt_mod, 0);
    btn_mode = 1'b0;
    hold(D + 5);
    chk("t6_release", gt_mod, 0);
    press(0, D + 5, tr);
    chk("t6_repress", gt_mod, 1);

    // random button activity with occasional reset
    for (int i = 0; i < 600; i++) begin
      int dur;
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_inc  = ($urandom_range(0, 2) == 0);
      rst_n    = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 4) == 0) dur = $urandom_range(1, 70);
      else dur = $urandom_range(1, 12);
      step();
      rst_n = 1'b1;
      hold(dur);
    end
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    hold(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
